// File: rtl/escritor_fecha_rtc.sv
// Write-side RTC date sequencer: latches the edited BCD date, validates it, then
// writes day/month/year and the transfer command over the multiplexed AD bus.
module escritor_fecha_rtc #(
  parameter int unsigned T_PULSO      = 4,
  parameter int unsigned T_ESPERA     = 4,
  parameter logic [7:0]  DIR_DIA      = 8'h24,
  parameter logic [7:0]  DIR_MES      = 8'h25,
  parameter logic [7:0]  DIR_ANO      = 8'h26,
  parameter logic [7:0]  DIR_TRANSFER = 8'hF1
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       iniciar,
  input  logic [7:0] IN_diaf,
  input  logic [7:0] IN_mesf,
  input  logic [7:0] IN_anof,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       AD_n,
  output logic       ocupado,
  output logic       listo,
  output logic       error_bcd
);

  typedef enum logic [2:0] {
    REPOSO, VALIDA, SETUP, STROBE, HOLD, GAP, FIN
  } estado_t;

  localparam logic [3:0] PULSO_FIN  = 4'(T_PULSO - 1);
  localparam logic [3:0] ESPERA_FIN = 4'(T_ESPERA - 1);

  estado_t    state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] dia_q, dia_d, mes_q, mes_d, ano_q, ano_d;

  logic [7:0] bus_q, bus_d;
  logic       oe_q, oe_d;
  logic       strb_q, strb_d;
  logic       ad_q, ad_d;
  logic       ocup_q, ocup_d;
  logic       listo_q, listo_d;
  logic       err_q, err_d;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // With valid nibbles, packed BCD compares in the same order as its decimal value.
  logic fecha_ok;
  assign fecha_ok = bcd_ok(dia_q) && bcd_ok(mes_q) && bcd_ok(ano_q) &&
                    (dia_q >= 8'h01) && (dia_q <= 8'h31) &&
                    (mes_q >= 8'h01) && (mes_q <= 8'h12);

  function automatic logic [7:0] valor_fase(input logic [2:0] i,
                                            input logic [7:0] d,
                                            input logic [7:0] m,
                                            input logic [7:0] a);
    case (i)
      3'd0:    return DIR_DIA;
      3'd1:    return d;
      3'd2:    return DIR_MES;
      3'd3:    return m;
      3'd4:    return DIR_ANO;
      3'd5:    return a;
      default: return DIR_TRANSFER;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dia_d   = dia_q;
    mes_d   = mes_q;
    ano_d   = ano_q;
    err_d   = 1'b0;
    case (state_q)
      REPOSO: begin
        if (iniciar) begin
          dia_d   = IN_diaf;
          mes_d   = IN_mesf;
          ano_d   = IN_anof;
          state_d = VALIDA;
        end
      end
      VALIDA: begin
        if (fecha_ok) begin
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          state_d = SETUP;
        end else begin
          err_d   = 1'b1;
          state_d = REPOSO;
        end
      end
      SETUP: begin
        cnt_d   = 4'd0;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == PULSO_FIN) begin
          cnt_d   = 4'd0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        cnt_d   = 4'd0;
        state_d = GAP;
      end
      GAP: begin
        if (cnt_q == ESPERA_FIN) begin
          cnt_d = 4'd0;
          if (idx_q == 3'd7) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SETUP;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      FIN:     state_d = REPOSO;
      default: state_d = REPOSO;
    endcase
  end

  // Outputs are decoded from the next state and registered, so pins are glitch-free
  // yet still line up with the state they describe.
  always_comb begin
    oe_d    = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    bus_d   = oe_d ? valor_fase(idx_d, dia_d, mes_d, ano_d) : 8'h00;
    ad_d    = oe_d ? idx_d[0] : 1'b1;
    strb_d  = (state_d == STROBE);
    ocup_d  = (state_d != REPOSO);
    listo_d = (state_d == FIN);
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      state_q <= REPOSO;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      dia_q   <= 8'h00;
      mes_q   <= 8'h00;
      ano_q   <= 8'h00;
      bus_q   <= 8'h00;
      oe_q    <= 1'b0;
      strb_q  <= 1'b0;
      ad_q    <= 1'b1;
      ocup_q  <= 1'b0;
      listo_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dia_q   <= dia_d;
      mes_q   <= mes_d;
      ano_q   <= ano_d;
      bus_q   <= bus_d;
      oe_q    <= oe_d;
      strb_q  <= strb_d;
      ad_q    <= ad_d;
      ocup_q  <= ocup_d;
      listo_q <= listo_d;
      err_q   <= err_d;
    end
  end

  assign bus_out   = bus_q;
  assign bus_oe    = oe_q;
  assign CS_n      = ~strb_q;
  assign WR_n      = ~strb_q;
  assign RD_n      = 1'b1;
  assign AD_n      = ad_q;
  assign ocupado   = ocup_q;
  assign listo     = listo_q;
  assign error_bcd = err_q;

endmodule

// File: tb/tb_escritor_fecha_rtc.sv
// Scoreboard bench for escritor_fecha_rtc: directed stimulus pushes expected bus
// writes / listo / error events; a negedge monitor pops and compares them.
module tb_escritor_fecha_rtc;

  logic       reloj = 1'b0;
  logic       resetM, iniciar, iniciar2;
  logic [7:0] IN_diaf, IN_mesf, IN_anof;
  logic [7:0] bus_out, bus_out2;
  logic       bus_oe, CS_n, WR_n, RD_n, AD_n, ocupado, listo, error_bcd;
  logic       bus_oe2, CS2_n, WR2_n, RD2_n, AD2_n, ocupado2, listo2, error2;

  always #5 reloj = ~reloj;

  escritor_fecha_rtc dut (
    .reloj(reloj), .resetM(resetM), .iniciar(iniciar),
    .IN_diaf(IN_diaf), .IN_mesf(IN_mesf), .IN_anof(IN_anof),
    .bus_out(bus_out), .bus_oe(bus_oe), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n),
    .AD_n(AD_n), .ocupado(ocupado), .listo(listo), .error_bcd(error_bcd)
  );

  escritor_fecha_rtc #(.T_PULSO(1), .T_ESPERA(1)) dut2 (
    .reloj(reloj), .resetM(resetM), .iniciar(iniciar2),
    .IN_diaf(IN_diaf), .IN_mesf(IN_mesf), .IN_anof(IN_anof),
    .bus_out(bus_out2), .bus_oe(bus_oe2), .CS_n(CS2_n), .WR_n(WR2_n), .RD_n(RD2_n),
    .AD_n(AD2_n), .ocupado(ocupado2), .listo(listo2), .error_bcd(error2)
  );

  typedef struct {
    int         kind;   // 0 bus write, 1 listo, 2 error_bcd
    logic [7:0] dat;
    logic       ad;
    int         lat;    // strobe width for writes, latency from iniciar otherwise
  } ev_t;

  ev_t q[$];
  int  tests = 0, fails = 0;
  int  cyc = 0, t_ini = 0;
  bit  inv_bad = 1'b0;

  always @(posedge reloj) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pop_check(input int kind, input logic [7:0] dat, input logic ad,
                           input int val, input bit stable);
    ev_t e;
    if (q.size() == 0) begin
      chk("evento_inesperado", kind, -1);
      return;
    end
    e = q.pop_front();
    chk("tipo_evento", kind, e.kind);
    if (kind == 0) begin
      chk("dato_bus", int'(dat), int'(e.dat));
      chk("AD_n_fase", int'(ad), int'(e.ad));
      chk("ancho_strobe", val, e.lat);
      chk("bus_estable", int'(stable), 1);
    end else begin
      chk("latencia", val, e.lat);
    end
  endtask

  // Monitor state for the default-parameter instance
  logic       prev_cs = 1'b1;
  int         low_cnt = 0;
  logic [7:0] cap_dat;
  logic       cap_ad;
  bit         stable;

  always @(negedge reloj) begin
    if (resetM) begin
      prev_cs = 1'b1;
      low_cnt = 0;
    end else begin
      if (CS_n != WR_n) inv_bad = 1'b1;
      if (!CS_n && !bus_oe) inv_bad = 1'b1;
      if (RD_n != 1'b1) inv_bad = 1'b1;
      if (listo && error_bcd) inv_bad = 1'b1;
      if (!CS_n) begin
        if (prev_cs) begin
          low_cnt = 1; cap_dat = bus_out; cap_ad = AD_n; stable = 1'b1;
        end else begin
          low_cnt++;
          if (bus_out != cap_dat || AD_n != cap_ad) stable = 1'b0;
        end
      end else if (!prev_cs) begin
        pop_check(0, cap_dat, cap_ad, low_cnt, stable);
      end
      prev_cs = CS_n;
      if (listo)     pop_check(1, 8'h00, 1'b0, cyc - t_ini, 1'b1);
      if (error_bcd) pop_check(2, 8'h00, 1'b0, cyc - t_ini, 1'b1);
    end
  end

  task automatic push_ev(input int kind, input logic [7:0] dat, input logic ad, input int lat);
    ev_t e;
    e.kind = kind; e.dat = dat; e.ad = ad; e.lat = lat;
    q.push_back(e);
  endtask

  task automatic push_writes(input logic [7:0] d, input logic [7:0] m,
                             input logic [7:0] a, input int nfases);
    logic [7:0] v [8];
    v[0] = 8'h24; v[1] = d; v[2] = 8'h25; v[3] = m;
    v[4] = 8'h26; v[5] = a; v[6] = 8'hF1; v[7] = 8'hF1;
    for (int i = 0; i < nfases; i++) push_ev(0, v[i], i[0], 4);
  endtask

  task automatic start();
    @(posedge reloj); #2 iniciar = 1'b1;
    @(posedge reloj); #2 iniciar = 1'b0;
    t_ini = cyc - 1;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge reloj);
      if (q.size() == 0 && !ocupado) begin ok = 1'b1; break; end
    end
    chk({nm, "_terminado"}, int'(ok), 1);
    repeat (5) @(negedge reloj);
    chk({nm, "_cola_vacia"}, q.size(), 0);
  endtask

  task automatic set_fecha(input logic [7:0] d, input logic [7:0] m, input logic [7:0] a);
    IN_diaf = d; IN_mesf = m; IN_anof = a;
  endtask

  logic [7:0] malos [4][3];

  initial begin
    int t2, lat2, low2, run2, maxrun2;
    resetM = 1'b1; iniciar = 1'b0; iniciar2 = 1'b0;
    set_fecha(8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge reloj);
    #2 resetM = 1'b0;

    // Idle after reset
    repeat (50) @(posedge reloj);
    @(negedge reloj);
    chk("rst_bus_out", int'(bus_out), 0);
    chk("rst_bus_oe", int'(bus_oe), 0);
    chk("rst_CS_n", int'(CS_n), 1);
    chk("rst_WR_n", int'(WR_n), 1);
    chk("rst_RD_n", int'(RD_n), 1);
    chk("rst_AD_n", int'(AD_n), 1);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_listo", int'(listo), 0);
    chk("rst_error", int'(error_bcd), 0);

    // Full valid sequence
    set_fecha(8'h29, 8'h10, 8'h99);
    push_writes(8'h29, 8'h10, 8'h99, 8);
    push_ev(1, 8'h00, 1'b0, 82);
    start();
    @(negedge reloj);
    chk("ocupado_tras_iniciar", int'(ocupado), 1);
    wait_done("secuencia_valida");

    // Rejected dates
    malos[0][0] = 8'h32; malos[0][1] = 8'h10; malos[0][2] = 8'h99;
    malos[1][0] = 8'h29; malos[1][1] = 8'h13; malos[1][2] = 8'h99;
    malos[2][0] = 8'h29; malos[2][1] = 8'h10; malos[2][2] = 8'h9A;
    malos[3][0] = 8'h00; malos[3][1] = 8'h10; malos[3][2] = 8'h99;
    for (int k = 0; k < 4; k++) begin
      set_fecha(malos[k][0], malos[k][1], malos[k][2]);
      push_ev(2, 8'h00, 1'b0, 2);
      start();
      wait_done("fecha_invalida");
    end

    // Restart ignored and input change mid-sequence
    set_fecha(8'h29, 8'h10, 8'h99);
    push_writes(8'h29, 8'h10, 8'h99, 8);
    push_ev(1, 8'h00, 1'b0, 82);
    start();
    repeat (33) @(posedge reloj);
    #2 iniciar = 1'b1; IN_mesf = 8'h05;
    @(posedge reloj); #2 iniciar = 1'b0;
    wait_done("reinicio_ignorado");
    IN_mesf = 8'h10;

    // Reset during STROBE of phase 4
    push_writes(8'h29, 8'h10, 8'h99, 4);
    start();
    repeat (43) @(posedge reloj);
    #2 resetM = 1'b1;
    @(posedge reloj);
    @(negedge reloj);
    chk("abort_CS_n", int'(CS_n), 1);
    chk("abort_WR_n", int'(WR_n), 1);
    chk("abort_bus_oe", int'(bus_oe), 0);
    chk("abort_ocupado", int'(ocupado), 0);
    @(posedge reloj); #2 resetM = 1'b0;
    chk("abort_fases_previas", q.size(), 0);
    repeat (5) @(posedge reloj);
    push_writes(8'h29, 8'h10, 8'h99, 8);
    push_ev(1, 8'h00, 1'b0, 82);
    start();
    wait_done("tras_abort");

    // Minimal timing instance
    @(posedge reloj); #2 iniciar2 = 1'b1;
    @(posedge reloj); #2 iniciar2 = 1'b0;
    t2 = cyc - 1; lat2 = -1; low2 = 0; run2 = 0; maxrun2 = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge reloj);
      if (!CS2_n) begin
        low2++; run2++;
        if (run2 > maxrun2) maxrun2 = run2;
      end else begin
        run2 = 0;
      end
      if (listo2 && lat2 < 0) lat2 = cyc - t2;
    end
    chk("rapido_latencia_listo", lat2, 34);
    chk("rapido_ciclos_strobe", low2, 8);
    chk("rapido_ancho_strobe", maxrun2, 1);

    chk("invariantes_bus", int'(inv_bad), 0);
    chk("cola_final", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/escritor_fecha_rtc.md
Name: escritor_fecha_rtc

Overview:
- Write-side sequencer for the date path. It takes the edited BCD day, month and year from the date-editing block and writes them to the external RTC over its multiplexed address/data bus.
- It then issues the RTC transfer command so the new date is committed.
- It is the counterpart to the read path that loads IN_diaf/IN_mesf/IN_anof. It sits between the date-editing block and the RTC bus arbiter.

Parameters:
- T_PULSO, 4, cycles CS_n/WR_n are held low per bus phase (range 1..15).
- T_ESPERA, 4, idle cycles after each phase with the bus released (range 1..15).
- DIR_DIA, 8'h24, RTC address of the day register.
- DIR_MES, 8'h25, RTC address of the month register.
- DIR_ANO, 8'h26, RTC address of the year register.
- DIR_TRANSFER, 8'hF1, RTC address of the time-transfer command.

Ports:
- reloj  in  1  system clock; all logic on rising edge.
- resetM  in  1  synchronous, active-high reset.
- iniciar  in  1  start request; sampled only in REPOSO.
- IN_diaf  in  8  day, packed BCD.
- IN_mesf  in  8  month, packed BCD.
- IN_anof  in  8  year, packed BCD.
- bus_out  out  8  value driven onto the RTC AD bus.
- bus_oe  out  1  1 = drive bus_out (tristate enable at top level).
- CS_n  out  1  RTC chip select, active low.
- WR_n  out  1  RTC write strobe, active low.
- RD_n  out  1  RTC read strobe; constant 1 in this block.
- AD_n  out  1  0 = address phase, 1 = data phase or idle.
- ocupado  out  1  high in every state except REPOSO.
- listo  out  1  one-cycle pulse when the full write sequence completes.
- error_bcd  out  1  one-cycle pulse when the latched date is rejected.

Behaviour:
- Reset (resetM=1 at a rising edge): state REPOSO, phase index 0, counters 0.
  - bus_out=8'h00, bus_oe=0, CS_n=1, WR_n=1, RD_n=1, AD_n=1, ocupado=0, listo=0, error_bcd=0.
  - Reset mid-sequence aborts immediately: bus released and strobes high on the cycle after the reset edge, no further phases.
- States: REPOSO, VALIDA, SETUP, STROBE, HOLD, GAP, FIN.
- REPOSO:
  - iniciar=1 latches IN_diaf/IN_mesf/IN_anof into internal registers and moves to VALIDA.
  - Later input changes have no effect until the next start.
- VALIDA (1 cycle): checks the latched values.
  - Every nibble must be ≤9.
  - Day 01..31, month 01..12, year 00..99.
  - Any failure: error_bcd=1 for exactly one cycle, then REPOSO; no bus activity and no listo.
  - Pass: phase index 0, go to SETUP.
- Phase sequence, index 0..7, value driven on bus_out:
  - 0: DIR_DIA; 1: day.
  - 2: DIR_MES; 3: month.
  - 4: DIR_ANO; 5: year.
  - 6: DIR_TRANSFER; 7: DIR_TRANSFER.
  - AD_n=0 for even indices and 1 for odd indices, held from SETUP through HOLD.
- SETUP (1 cycle): bus_oe=1, bus_out and AD_n valid, CS_n=WR_n=1.
- STROBE (T_PULSO cycles): CS_n=0, WR_n=0; bus_out and AD_n stable.
- HOLD (1 cycle): CS_n=WR_n=1; bus_oe=1 and bus_out unchanged.
- GAP (T_ESPERA cycles): bus_oe=0, bus_out=8'h00, AD_n=1, strobes high.
  - At the end of GAP: if index=7 go to FIN, else increment index and go to SETUP.
- FIN (1 cycle): listo=1, then REPOSO.
- Timing:
  - Cycles per phase: T_PULSO+T_ESPERA+2, which is 10 with the default parameters.
  - Total from the iniciar edge to the listo cycle: 1 (VALIDA) + 8×(T_PULSO+T_ESPERA+2) + 1, which is 82 with defaults.
  - The first SETUP occurs 2 cycles after the iniciar edge.
- iniciar asserted while ocupado=1 is ignored; it is not queued.
- CS_n and WR_n always change together and are never low while bus_oe=0.
- AD_n never changes while CS_n=0.
- listo and error_bcd are never asserted in the same sequence.
- The phase counter is 3 bits. The cycle counter is 4 bits, compared against T_PULSO-1 and T_ESPERA-1, with no wrap beyond these values.

Test Plan:
- Reset then idle, no iniciar for 50 cycles -> all outputs at their reset values, ocupado=0.
- Inputs 29/10/99 (hex BCD), iniciar pulsed 1 cycle, default parameters:
  - Bus writes in order 24,29,25,10,26,99,F1,F1.
  - AD_n pattern 0,1,0,1,0,1,0,1.
  - Each CS_n/WR_n low for exactly 4 cycles.
  - listo exactly 82 cycles after the iniciar edge.
- Invalid inputs, each followed by iniciar, in separate runs: day 8'h32, month 8'h13, year 8'h9A, day 8'h00 -> error_bcd 1-cycle pulse 2 cycles after iniciar, CS_n stays 1, no listo.
- iniciar re-pulsed during phase 3, and IN_mesf changed to 8'h05 mid-sequence -> sequence unaffected, month written as 10, a single listo.
- resetM asserted during STROBE of phase 4 -> next cycle CS_n=WR_n=1, bus_oe=0, ocupado=0; a new iniciar then runs a full sequence from phase 0.
- T_PULSO=1, T_ESPERA=1 -> 4 cycles per phase, listo 34 cycles after iniciar, strobe width 1 cycle.
